// File: rtl/switch_port_in_pkg.sv
// Shared constants for the front-panel switch input port: timing defaults,
// switch count and the CPU port-select encodings.
package switch_port_in_pkg;

  localparam int TICK_DIV_DEFAULT    = 25000;  // 1 ms sample tick at 25 MHz
  localparam int DEB_SAMPLES_DEFAULT = 4;
  localparam int NUM_SW              = 8;

  typedef enum logic {
    PORT_DATA   = 1'b0,
    PORT_STATUS = 1'b1
  } port_sel_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchronizer, tick-sampled history and the
// accept logic that moves the debounced level once the history agrees.
module sw_debounce
  import switch_port_in_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic toggle
);

  logic [1:0]             sync;
  logic [DEB_SAMPLES-1:0] hist;
  logic                   tickD;
  logic                   sample;
  logic                   allOn;
  logic                   allOff;

  // Raw input is active-low; everything past the synchronizer is active-high.
  assign sample = ~sync[1];
  assign allOn  = &hist;
  assign allOff = ~|hist;

  // The decision is made one cycle after the tick, on the freshly shifted history.
  assign toggle = tickD && ((allOn && !level) || (allOff && level));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      hist  <= '0;
      tickD <= 1'b0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      tickD <= tick;
      if (tick) begin
        hist <= (hist << 1) | DEB_SAMPLES'(sample);
      end
      level <= level ^ toggle;
    end
  end

endmodule

// File: rtl/switch_port_in.sv
// Front-panel switch input port: shared sample prescaler, eight debounced
// channels, a sticky change latch with interrupt, and the CPU read mux.
module switch_port_in
  import switch_port_in_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
  input  logic       pll0_25MHz,
  input  logic       reset,
  input  logic [7:0] swRaw,
  input  logic       portSel,
  input  logic       rdStrobe,
  output logic [7:0] portDataOut,
  output logic [7:0] swState,
  output logic       swIrq
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]  prescale;
  logic              tick;
  logic [NUM_SW-1:0] toggle;
  logic [NUM_SW-1:0] swChanged;
  logic              statusRead;

  assign tick = (prescale == CNT_LAST);

  always_ff @(posedge pll0_25MHz or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce #(
      .DEB_SAMPLES(DEB_SAMPLES)
    ) u_deb (
      .clk    (pll0_25MHz),
      .rst    (reset),
      .tick   (tick),
      .raw    (swRaw[i]),
      .level  (swState[i]),
      .toggle (toggle[i])
    );
  end

  // CPU read: rdStrobe marks a read on every cycle it is high (no ready, no
  // back-pressure); data appears on portDataOut the following cycle. Only a
  // status-port read has a side effect: it clears the change latch.
  assign statusRead = rdStrobe && (portSel == PORT_STATUS);

  always_ff @(posedge pll0_25MHz or posedge reset) begin
    if (reset) begin
      swChanged   <= '0;
      portDataOut <= '0;
      swIrq       <= 1'b0;
    end else begin
      // A toggle on the clearing edge wins, so no change is ever dropped.
      swChanged   <= toggle | (statusRead ? '0 : swChanged);
      portDataOut <= (portSel == PORT_STATUS) ? swChanged : swState;
      swIrq       <= |swChanged;
    end
  end

endmodule

// File: tb/tb_switch_port_in.sv
// Directed bench for switch_port_in with a behavioural run-length debounce
// model, an expected-value queue checked every cycle, and literal checkpoints.
module tb_switch_port_in;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] swRaw = 8'hFF;
  logic       portSel = 1'b0;
  logic       rdStrobe = 1'b0;
  logic [7:0] portDataOut;
  logic [7:0] swState;
  logic       swIrq;

  int nChecks = 0;
  int nFails  = 0;
  bit compEn  = 1'b0;

  switch_port_in #(
    .TICK_DIV    (TICK_DIV),
    .DEB_SAMPLES (DEB)
  ) dut (
    .pll0_25MHz  (clk),
    .reset       (reset),
    .swRaw       (swRaw),
    .portSel     (portSel),
    .rdStrobe    (rdStrobe),
    .portDataOut (portDataOut),
    .swState     (swState),
    .swIrq       (swIrq)
  );

  // ---------------- clock ----------------
  always #20 clk = ~clk;

  // ---------------- model ----------------
  // Each switch is tracked as "last accepted sample and how many ticks in a
  // row it has been seen"; the level moves once that run reaches DEB.
  logic [7:0]  mState, mChanged, mData, mPred, mSync, mToggle;
  logic        mIrq;
  bit          mDecide;
  int          mEdges;
  logic [7:0]  mPipe[$];
  bit          mLast[8];
  int          mRun[8];
  logic [16:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = '0; mChanged = '0; mData = '0; mIrq = 1'b0; mPred = '0;
      mDecide = 1'b0; mEdges = 0;
      mPipe.delete(); mPipe.push_back(8'hFF); mPipe.push_back(8'hFF);
      for (int i = 0; i < 8; i++) begin mLast[i] = 1'b0; mRun[i] = DEB; end
    end else begin
      mSync = mPipe.pop_front();
      mPipe.push_back(swRaw);
      mToggle = '0;
      if (mDecide)
        for (int i = 0; i < 8; i++)
          if (mRun[i] >= DEB && mLast[i] != mState[i]) mToggle[i] = 1'b1;
      mData    = portSel ? mChanged : mState;
      mIrq     = |mChanged;
      mChanged = mToggle | ((portSel && rdStrobe) ? 8'h00 : mChanged);
      mState   = mState ^ mToggle;
      mDecide  = ((mEdges % TICK_DIV) == TICK_DIV - 1);
      if (mDecide)
        for (int i = 0; i < 8; i++) begin
          if (bit'(~mSync[i]) == mLast[i]) begin
            if (mRun[i] < DEB) mRun[i]++;
          end else begin
            mLast[i] = ~mSync[i];
            mRun[i]  = 1;
          end
        end
      mEdges++;
      mPred = '0;
      if (mDecide)
        for (int i = 0; i < 8; i++)
          if (mRun[i] >= DEB && mLast[i] != mState[i]) mPred[i] = 1'b1;
    end
    exp_q.push_back({mState, mData, mIrq});
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (compEn) begin
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      if (exp_q.size() == 1) begin
        e = exp_q.pop_front();
        chk("model_swState", swState, e[16:9]);
        chk("model_portDataOut", portDataOut, e[8:1]);
        chk("model_swIrq", {7'b0, swIrq}, {7'b0, e[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) step();
  endtask

  task automatic readPort(input logic sel);
    portSel  = sel;
    rdStrobe = 1'b1;
    step();
    rdStrobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit found;
    repeat (3) @(negedge clk);
    compEn = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle with all switches off.
    waitCycles(100);
    readPort(1'b0);
    @(negedge clk);
    chk("idle_swState", swState, 8'h00);
    chk("idle_swIrq", {7'b0, swIrq}, 8'h00);
    chk("idle_dataRead", portDataOut, 8'h00);

    // Switch 0 on.
    swRaw = 8'hFE;
    waitCycles(30);
    @(negedge clk);
    chk("on0_swState", swState, 8'h01);
    chk("on0_swIrq", {7'b0, swIrq}, 8'h01);
    readPort(1'b1);
    @(negedge clk);
    chk("on0_statusRead", portDataOut, 8'h01);
    step();
    @(negedge clk);
    chk("on0_irqCleared", {7'b0, swIrq}, 8'h00);
    chk("on0_changedCleared", portDataOut, 8'h00);
    portSel = 1'b0;

    // Three-cycle glitch on switch 3.
    swRaw = 8'hF6;
    waitCycles(3);
    swRaw = 8'hFE;
    waitCycles(30);
    @(negedge clk);
    chk("glitch_swState", swState, 8'h01);
    chk("glitch_swIrq", {7'b0, swIrq}, 8'h00);
    readPort(1'b1);
    @(negedge clk);
    chk("glitch_statusRead", portDataOut, 8'h00);
    portSel = 1'b0;

    // Status read on the very edge switch 5 is accepted.
    swRaw = 8'hEE;
    waitCycles(30);
    @(negedge clk);
    chk("on4_swState", swState, 8'h11);
    swRaw = 8'hCE;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mPred[5]) begin
        found = 1'b1;
        break;
      end
    end
    chk("race_alignFound", {7'b0, found}, 8'h01);
    readPort(1'b1);
    @(negedge clk);
    chk("race_readOld", portDataOut, 8'h10);
    chk("race_swState", swState, 8'h31);
    chk("race_swIrq", {7'b0, swIrq}, 8'h01);
    step();
    @(negedge clk);
    chk("race_irqHeld", {7'b0, swIrq}, 8'h01);
    chk("race_bit5Kept", portDataOut, 8'h20);
    readPort(1'b1);
    waitCycles(2);
    portSel = 1'b0;

    // Reset while switch 2 is two ticks into its debounce.
    swRaw = 8'hCA;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mLast[2] && mRun[2] == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_alignFound", {7'b0, found}, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_swState", swState, 8'h00);
    chk("rst_portDataOut", portDataOut, 8'h00);
    chk("rst_swIrq", {7'b0, swIrq}, 8'h00);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(16);
    @(negedge clk);
    chk("rst_noEarlyAccept", swState, 8'h00);
    chk("rst_noChangeFromReset", {7'b0, swIrq}, 8'h00);
    step();
    @(negedge clk);
    chk("rst_fullDebounce", swState, 8'h35);
    step();

    // Held strobe: two back-to-back status reads.
    portSel  = 1'b1;
    rdStrobe = 1'b1;
    step();
    @(negedge clk);
    chk("held_firstRead", portDataOut, 8'h35);
    step();
    @(negedge clk);
    chk("held_secondRead", portDataOut, 8'h00);
    rdStrobe = 1'b0;
    portSel  = 1'b0;

    // Switch 7 on then off again.
    swRaw = 8'h4A;
    waitCycles(30);
    @(negedge clk);
    chk("b7_on", swState, 8'hB5);
    swRaw = 8'hCA;
    waitCycles(30);
    @(negedge clk);
    chk("b7_off", swState, 8'h35);
    chk("b7_swIrq", {7'b0, swIrq}, 8'h01);
    readPort(1'b1);
    @(negedge clk);
    chk("b7_statusRead", portDataOut, 8'h80);
    step();
    @(negedge clk);
    chk("b7_irqCleared", {7'b0, swIrq}, 8'h00);
    portSel = 1'b0;
    waitCycles(4);

    // ---------------- report ----------------
    @(negedge clk);
    compEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/switch_port_in.md
SWITCH_PORT_IN -- requirements
Module: switch_port_in

Interface
REQ-001 Parameter TICK_DIV, default 25000; the sample-tick period in clock cycles, which gives 1 ms at 25 MHz.
REQ-002 Parameter DEB_SAMPLES, default 4; the number of consecutive equal samples needed to accept a new switch level.
REQ-003 pll0_25MHz  input  1  Sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 swRaw  input  8  Raw front-panel switches; asynchronous; active-low (0 = switch ON).
REQ-006 portSel  input  1  CPU port select: 0 = data port, 1 = change-status port.
REQ-007 rdStrobe  input  1  One-cycle CPU read pulse for the port chosen by portSel.
REQ-008 portDataOut  output  8  Registered CPU read data.
REQ-009 swState  output  8  Debounced switch levels, active-high (1 = ON).
REQ-010 swIrq  output  1  Change interrupt; high while any change-latch bit is set.

Function
REQ-011 Each swRaw bit shall pass through a 2-flop synchronizer and then be inverted to active-high before any other use.
REQ-012 A prescaler shall count 0..TICK_DIV-1 and wrap to 0; tick is high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-013 On each tick, each bit shall shift its synchronized sample into a DEB_SAMPLES-deep history register.
REQ-014 swState[i] shall update on the cycle after a tick when all DEB_SAMPLES history samples of bit i are equal and differ from swState[i]; otherwise swState[i] holds.
REQ-015 Total debounce latency from a stable raw level to swState: 2 sync cycles plus DEB_SAMPLES ticks, plus 1 cycle; a glitch shorter than one tick period shall never change swState.
REQ-016 swChanged[7:0] (internal) bit i shall set on any cycle in which swState[i] toggles, in either direction.
REQ-017 A status read (rdStrobe=1, portSel=1) shall clear all swChanged bits on the next edge.
REQ-018 If a bit toggles in the same cycle as a status read, that bit's set shall win and it stays 1; the other bits clear.
REQ-019 portDataOut shall register, every cycle, swState when portSel=0 and swChanged when portSel=1, with 1-cycle latency.
REQ-020 On a status read, portDataOut shall capture the pre-clear swChanged value, so no change is lost.
REQ-021 Data reads (portSel=0) shall have no side effects.
REQ-022 swIrq shall be the registered OR of swChanged, asserting 1 cycle after the set and deasserting 1 cycle after the clear.
REQ-023 A rdStrobe held for multiple cycles is legal; each strobed cycle is a read, and repeated clears are idempotent.

Reset
REQ-024 While reset is high: synchronizer flops = 8'hFF (switches OFF), history registers = 0, swState = 0, swChanged = 0, prescaler = 0, portDataOut = 0, swIrq = 0.
REQ-025 Reset asserted mid-debounce shall discard the partial history; no swChanged bit sets as a result of reset.
REQ-026 After deassertion, the first tick occurs TICK_DIV cycles later.

Structure
REQ-027 The TICK_DIV and DEB_SAMPLES defaults and the port-select encodings shall live in the shared project constants include.
REQ-028 The per-bit synchronizer, history register and accept logic shall be one sub-module, sw_debounce, instantiated 8 times; the prescaler, change latch and read mux stay in the top module.
REQ-029 Target size: about 150-250 RTL lines in total.

Verification (TICK_DIV=4, DEB_SAMPLES=4)
REQ-030 Reset, then swRaw=8'hFF idle for 100 cycles -> swState=0, swIrq=0, and a data read returns 8'h00.
REQ-031 swRaw drives 8'hFE stably -> swState=8'h01 within 2+16+1 cycles (+ tick phase); swIrq=1; a status read returns 8'h01; swIrq=0 afterwards.
REQ-032 A 3-cycle low glitch on swRaw[3] -> swState and swChanged unchanged; swIrq stays 0.
REQ-033 Status read issued on the same cycle swState[5] toggles -> the read returns the old swChanged value, swChanged[5] stays 1, and swIrq stays 1.
REQ-034 Reset asserted while bit 2 is 2 ticks into debouncing -> all outputs 0; after release, the bit takes a full DEB_SAMPLES ticks again.
REQ-035 Bit 7 toggles ON then OFF -> swChanged[7]=1 is latched once, and swState[7]=0 at the end.
